regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- Shares that port between two writers:
  - the in-order pipeline writeback stage (W), which has priority;
  - the multicycle mult/div unit (MD), which uses a valid/ready handshake.
- Keeps a busy scoreboard for MD destination registers and raises a decode hazard stall.
- Prevents MD starvation by forcing a one-cycle pipeline bubble after MAX_WAIT lost arbitrations.

Parameters:
- MAX_WAIT, 4, consecutive cycles MD may lose arbitration before a forced bubble (legal range 1..15).
- CNT_W, 4, width of the wait counter.

Ports:
- clock  in  1  system clock
- ctrl_reset  in  1  asynchronous, active-high reset
- wb_we  in  1  W stage write request
- wb_rd  in  5  W stage destination register
- wb_data  in  32  W stage write data
- md_issue  in  1  MD op issued from decode this cycle
- md_issue_rd  in  5  destination register of the issued MD op
- md_valid  in  1  MD result valid; held until accepted
- md_rd  in  5  MD result destination register
- md_data  in  32  MD result data
- md_ready  out  1  MD result accepted this cycle
- id_rs_a, id_rs_b  in  5 each  decode source registers
- id_rd  in  5  decode destination register
- id_we  in  1  decode instruction writes id_rd
- hazard_stall  out  1  decode must stall (RAW or WAW on a busy register)
- pipe_stall  out  1  forced bubble; W must hold its request and retry
- ctrl_writeEnable  out  1  register file write enable
- ctrl_writeReg  out  5  register file write address
- data_writeReg  out  32  register file write data
- busy_vec  out  32  scoreboard, exported for debug

Behaviour:
- Reset: ctrl_reset (asynchronous, active-high) clears busy_vec, the wait counter and the state, and puts the state machine in IDLE. While reset is asserted, all outputs are 0.
- Write-port mux is combinational, same cycle. The register file captures the write on the next posedge.
- Writes to r0:
  - wb_rd==0 is treated as no request.
  - An MD result to r0 is still accepted through the handshake, but ctrl_writeEnable stays 0.
- Arbitration:
  - wb_act = wb_we & (wb_rd!=0).
  - In states IDLE and WAIT: W wins if wb_act; otherwise MD is granted when md_valid.
  - md_ready = md_valid & (!wb_act | state==FORCE).
  - The grantee drives ctrl_writeReg and data_writeReg.
  - When there is no grant: ctrl_writeEnable=0, address=0, data=0.
- State machine (registered):
  - IDLE -> WAIT when md_valid & !md_ready; the counter loads 1.
  - WAIT -> IDLE when md_ready.
  - WAIT -> WAIT while still lost; the counter increments.
  - WAIT -> FORCE when the counter == MAX_WAIT and MD is still lost.
  - FORCE: pipe_stall=1 (combinational from state), MD is granted unconditionally, and the W request is ignored; W holds and retries next cycle. FORCE -> IDLE after exactly one cycle, and the counter clears.
  - MAX_WAIT=1 means a single loss goes to FORCE.
- Scoreboard:
  - md_issue with md_issue_rd!=0 sets busy_vec[md_issue_rd] at the next posedge.
  - An MD acceptance (md_valid & md_ready) clears busy_vec[md_rd].
  - If a set and a clear hit the same index in the same cycle, the set wins.
  - busy_vec[0] is always 0.
- Hazard:
  - hazard_stall = busy[id_rs_a] | busy[id_rs_b] | (id_we & busy[id_rd]). Combinational, using the registered busy_vec.
  - There is no bypass of a same-cycle clear; the stall releases the cycle after acceptance.
- Any cycle with md_valid low returns the state machine to IDLE (MD withdrawal is illegal, but the block tolerates it).

Decomposition:
- Shared package (processor defs): REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, and the state encoding IDLE=2'd0, WAIT=2'd1, FORCE=2'd2.
- One natural sub-module: wb_scoreboard, containing busy_vec with set/clear/read logic and the hazard compare.
- Arbitration, the counter and the state machine stay in the top module.

Test Plan:
- Reset mid-operation: busy_vec=32'h0000_0010 in state WAIT; assert ctrl_reset -> busy_vec=0, state IDLE, all outputs 0 immediately (asynchronous).
- W alone: wb_we=1, wb_rd=3, wb_data=32'hDEAD_BEEF -> ctrl_writeEnable=1, ctrl_writeReg=3, data same cycle; the register file reads 32'hDEAD_BEEF at r3 after the posedge.
- Collision: W rd=5 and md_valid rd=7 in the same cycle -> W written, md_ready=0. The next cycle with wb_we=0 -> md_ready=1, r7 written, state back to IDLE.
- Starvation, MAX_WAIT=4: wb_we held high for 6 cycles while MD is pending -> md_ready=0 for 4 cycles, then pipe_stall=1 with MD written in cycle 5, then W resumes in cycle 6.
- Scoreboard hazard: md_issue rd=9; then id_rs_a=9 -> hazard_stall=1 until the MD result for r9 is accepted, and 0 the following cycle. id_rd=9 with id_we=1 also stalls.
- Set/clear same cycle and r0: MD accept for rd=9 coincides with md_issue rd=9 -> busy_vec[9] stays 1. MD result to rd=0 -> md_ready=1, ctrl_writeEnable=0, busy_vec[0]=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared processor definitions for the register file write-port arbiter.
// Holds the register-file geometry and the arbiter state encoding.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StForce = 2'd2
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback, mult/div, decode and register-file write-port signals.
// The arbiter uses the slave modport; the surrounding pipeline uses master.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic      wb_we;
  reg_addr_t wb_rd;
  reg_data_t wb_data;

  logic      md_issue;
  reg_addr_t md_issue_rd;
  logic      md_valid;
  reg_addr_t md_rd;
  reg_data_t md_data;
  logic      md_ready;

  reg_addr_t id_rs_a;
  reg_addr_t id_rs_b;
  reg_addr_t id_rd;
  logic      id_we;
  logic      hazard_stall;

  logic      pipe_stall;
  logic      ctrl_writeEnable;
  reg_addr_t ctrl_writeReg;
  reg_data_t data_writeReg;
  reg_mask_t busy_vec;

  modport slave (
    input  wb_we, wb_rd, wb_data,
    input  md_issue, md_issue_rd, md_valid, md_rd, md_data,
    output md_ready,
    input  id_rs_a, id_rs_b, id_rd, id_we,
    output hazard_stall, pipe_stall,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_vec
  );

  modport master (
    output wb_we, wb_rd, wb_data,
    output md_issue, md_issue_rd, md_valid, md_rd, md_data,
    input  md_ready,
    output id_rs_a, id_rs_b, id_rd, id_we,
    input  hazard_stall, pipe_stall,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_vec
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Busy scoreboard for outstanding mult/div destinations plus the decode hazard compare.
// An issue-set beats an acceptance-clear on the same register; r0 is never busy.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic      clock,
  input  logic      ctrl_reset,
  input  logic      md_issue,
  input  reg_addr_t md_issue_rd,
  input  logic      md_accept,
  input  reg_addr_t md_rd,
  input  reg_addr_t id_rs_a,
  input  reg_addr_t id_rs_b,
  input  reg_addr_t id_rd,
  input  logic      id_we,
  output reg_mask_t busy_vec,
  output logic      hazard_stall
);

  reg_mask_t busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (md_accept) begin
      busy_d[md_rd] = 1'b0;
    end
    if (md_issue && (md_issue_rd != '0)) begin
      busy_d[md_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // No bypass of a same-cycle clear: the stall drops one cycle after acceptance.
  assign hazard_stall = busy_q[id_rs_a] | busy_q[id_rs_b] | (id_we & busy_q[id_rd]);
  assign busy_vec     = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the single register-file write port, shared between writeback (priority) and
// the mult/div unit, with a forced pipeline bubble after MAX_WAIT consecutive MD losses.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input logic                 clock,
  input logic                 ctrl_reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] MaxWaitCnt = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] OneCnt     = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic      wb_act;
  logic      in_force;
  logic      md_ready_raw;
  logic      w_grant;
  logic      md_accept;
  logic      we;
  reg_addr_t addr;
  reg_data_t data;

  // Write-port mux; in the forced-bubble cycle the W request is ignored and W retries.
  always_comb begin
    wb_act       = bus.wb_we & (bus.wb_rd != '0);
    in_force     = (state_q == StForce);
    md_ready_raw = bus.md_valid & (~wb_act | in_force);
    w_grant      = wb_act & ~in_force;
    we           = 1'b0;
    addr         = '0;
    data         = '0;
    if (w_grant) begin
      we   = 1'b1;
      addr = bus.wb_rd;
      data = bus.wb_data;
    end else if (md_ready_raw) begin
      we   = (bus.md_rd != '0);
      addr = bus.md_rd;
      data = bus.md_data;
    end
  end

  assign md_accept            = md_ready_raw & ~ctrl_reset;
  assign bus.md_ready         = md_accept;
  assign bus.pipe_stall       = in_force;
  assign bus.ctrl_writeEnable = we & ~ctrl_reset;
  assign bus.ctrl_writeReg    = ctrl_reset ? '0 : addr;
  assign bus.data_writeReg    = ctrl_reset ? '0 : data;

  // cnt_q counts consecutive losses so far; cnt_inc includes the current loss.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + OneCnt;
    if (!bus.md_valid) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!md_ready_raw) begin
            state_d = (MaxWaitCnt == OneCnt) ? StForce : StWait;
            cnt_d   = OneCnt;
          end
        end
        StWait: begin
          if (md_ready_raw) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == MaxWaitCnt) begin
              state_d = StForce;
            end
          end
        end
        StForce: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  wb_scoreboard u_scoreboard (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .md_issue     (bus.md_issue),
    .md_issue_rd  (bus.md_issue_rd),
    .md_accept    (md_accept),
    .md_rd        (bus.md_rd),
    .id_rs_a      (bus.id_rs_a),
    .id_rs_b      (bus.id_rs_b),
    .id_rd        (bus.id_rd),
    .id_we        (bus.id_we),
    .busy_vec     (bus.busy_vec),
    .hazard_stall (bus.hazard_stall)
  );

endmodule
